// File: rtl/alu_resp_checker_if.sv
// Operand/result bus seen by the ALU response checker, plus its status outputs.
interface alu_resp_checker_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             i_start;
    logic             i_stop;
    logic             i_valid;
    logic [N-1:0]     i_a;
    logic [N-1:0]     i_b;
    logic [2:0]       i_f;
    logic [N-1:0]     i_alu_op;
    logic             i_c_out;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_pass_cnt;
    logic [CNT_W-1:0] o_fail_cnt;
    logic             o_err;
    logic [2:0]       o_err_f;
    logic [N-1:0]     o_err_exp;
    logic [N-1:0]     o_err_got;

    // Stimulus side: drives operands and the ALU outputs, observes stats.
    modport master (
        output i_start, i_stop, i_valid, i_a, i_b, i_f, i_alu_op, i_c_out,
        input  o_busy, o_done, o_pass_cnt, o_fail_cnt, o_err, o_err_f, o_err_exp, o_err_got
    );

    // Checker side.
    modport slave (
        input  i_start, i_stop, i_valid, i_a, i_b, i_f, i_alu_op, i_c_out,
        output o_busy, o_done, o_pass_cnt, o_fail_cnt, o_err, o_err_f, o_err_exp, o_err_got
    );
endinterface

// File: rtl/alu_resp_checker.sv
// Response checker for the N-bit ALU: recomputes each sample, counts pass/fail,
// captures the first mismatch. Compare happens at accept time so the FSM can stop
// on that same edge; stats update one edge later from the stage-1 regs.
module alu_resp_checker #(
    parameter int N           = 32,
    parameter int CNT_W       = 16,
    parameter int MAX_SAMPLES = 0,
    parameter int STOP_ON_ERR = 0
) (
    input logic               i_clk,
    input logic               i_rstn,
    alu_resp_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [31:0]      MAX_S   = MAX_SAMPLES;

    state_t           state_q, state_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s1_mis_q, s1_mis_d;
    logic [2:0]       s1_f_q, s1_f_d;
    logic [N-1:0]     s1_exp_q, s1_exp_d;
    logic [N-1:0]     s1_got_q, s1_got_d;
    logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             err_q, err_d;
    logic [2:0]       err_f_q, err_f_d;
    logic [N-1:0]     err_exp_q, err_exp_d;
    logic [N-1:0]     err_got_q, err_got_d;

    logic [N-1:0]     bx;
    logic [N:0]       sum;
    logic [N-1:0]     exp_op;
    logic             exp_c;
    logic             mism;
    logic             accept;
    logic             max_hit;

    // Reference model: shared adder handles add, subtract and the carry for every F.
    always_comb begin
        bx     = bus.i_f[2] ? ~bus.i_b : bus.i_b;
        sum    = {1'b0, bus.i_a} + {1'b0, bx} + {{N{1'b0}}, bus.i_f[2]};
        exp_c  = sum[N];
        exp_op = '0;
        case (bus.i_f)
            3'b000:  exp_op = bus.i_a & bus.i_b;
            3'b001:  exp_op = bus.i_a | bus.i_b;
            3'b010:  exp_op = sum[N-1:0];
            3'b011:  exp_op = '0;
            3'b100:  exp_op = bus.i_a & ~bus.i_b;
            3'b101:  exp_op = bus.i_a | ~bus.i_b;
            3'b110:  exp_op = sum[N-1:0];
            default: exp_op = {{(N-1){1'b0}}, ($signed(bus.i_a) < $signed(bus.i_b))};
        endcase
        mism = {exp_op, exp_c} != {bus.i_alu_op, bus.i_c_out};
    end

    // Next state: accept/capture, saturating stats, FSM; start overrides everything.
    always_comb begin
        state_d    = state_q;
        s1_vld_d   = 1'b0;
        s1_mis_d   = s1_mis_q;
        s1_f_d     = s1_f_q;
        s1_exp_d   = s1_exp_q;
        s1_got_d   = s1_got_q;
        samp_cnt_d = samp_cnt_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        err_d      = err_q;
        err_f_d    = err_f_q;
        err_exp_d  = err_exp_q;
        err_got_d  = err_got_q;

        accept  = (state_q == RUN) && bus.i_valid && !bus.i_start;
        max_hit = accept && (MAX_S != 32'd0) && ((32'(samp_cnt_q) + 32'd1) == MAX_S);

        if (accept) begin
            s1_vld_d = 1'b1;
            s1_mis_d = mism;
            s1_f_d   = bus.i_f;
            s1_exp_d = exp_op;
            s1_got_d = bus.i_alu_op;
            if (samp_cnt_q != CNT_MAX) samp_cnt_d = samp_cnt_q + 1'b1;
        end

        // Stage 1 is counted even after the FSM has left RUN.
        if (s1_vld_q) begin
            if (s1_mis_q) begin
                if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
                if (!err_q) begin
                    err_d     = 1'b1;
                    err_f_d   = s1_f_q;
                    err_exp_d = s1_exp_q;
                    err_got_d = s1_got_q;
                end
            end else if (pass_cnt_q != CNT_MAX) begin
                pass_cnt_d = pass_cnt_q + 1'b1;
            end
        end

        case (state_q)
            RUN: if (bus.i_stop || max_hit || ((STOP_ON_ERR != 0) && accept && mism))
                     state_d = DONE;
            default: ;
        endcase

        if (bus.i_start) begin
            state_d    = RUN;
            s1_vld_d   = 1'b0;
            samp_cnt_d = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_d      = 1'b0;
            err_f_d    = '0;
            err_exp_d  = '0;
            err_got_d  = '0;
        end
    end

    // State and stat registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            s1_vld_q   <= 1'b0;
            s1_mis_q   <= 1'b0;
            s1_f_q     <= '0;
            s1_exp_q   <= '0;
            s1_got_q   <= '0;
            samp_cnt_q <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_q      <= 1'b0;
            err_f_q    <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else begin
            state_q    <= state_d;
            s1_vld_q   <= s1_vld_d;
            s1_mis_q   <= s1_mis_d;
            s1_f_q     <= s1_f_d;
            s1_exp_q   <= s1_exp_d;
            s1_got_q   <= s1_got_d;
            samp_cnt_q <= samp_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            err_q      <= err_d;
            err_f_q    <= err_f_d;
            err_exp_q  <= err_exp_d;
            err_got_q  <= err_got_d;
        end
    end

    assign bus.o_busy     = (state_q == RUN);
    assign bus.o_done     = (state_q == DONE);
    assign bus.o_pass_cnt = pass_cnt_q;
    assign bus.o_fail_cnt = fail_cnt_q;
    assign bus.o_err      = err_q;
    assign bus.o_err_f    = err_f_q;
    assign bus.o_err_exp  = err_exp_q;
    assign bus.o_err_got  = err_got_q;
endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed bench: four checker configurations share one stimulus stream.
module tb_alu_resp_checker;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0, stop = 1'b0, valid = 1'b0, c = 1'b0;
    logic [31:0] a = '0, b = '0, op = '0;
    logic [2:0]  f = '0;
    logic [102:0] stim;
    int          total = 0;
    int          bad = 0;

    // Hand-computed results for A=0000_000C, B=0000_000A, indexed by F.
    logic [31:0] eop [8] = '{32'h8, 32'hE, 32'h16, 32'h0, 32'h4, 32'hFFFF_FFFD, 32'h2, 32'h0};
    logic        ec  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    alu_resp_checker_if #(.N(32), .CNT_W(16)) if0 ();
    alu_resp_checker_if #(.N(32), .CNT_W(16)) if1 ();
    alu_resp_checker_if #(.N(32), .CNT_W(16)) if2 ();
    alu_resp_checker_if #(.N(32), .CNT_W(2))  if3 ();

    assign stim = {start, stop, valid, a, b, f, op, c};
    assign {if0.i_start, if0.i_stop, if0.i_valid, if0.i_a, if0.i_b, if0.i_f, if0.i_alu_op, if0.i_c_out} = stim;
    assign {if1.i_start, if1.i_stop, if1.i_valid, if1.i_a, if1.i_b, if1.i_f, if1.i_alu_op, if1.i_c_out} = stim;
    assign {if2.i_start, if2.i_stop, if2.i_valid, if2.i_a, if2.i_b, if2.i_f, if2.i_alu_op, if2.i_c_out} = stim;
    assign {if3.i_start, if3.i_stop, if3.i_valid, if3.i_a, if3.i_b, if3.i_f, if3.i_alu_op, if3.i_c_out} = stim;

    alu_resp_checker d0 (.i_clk(clk), .i_rstn(rstn), .bus(if0));
    alu_resp_checker #(.STOP_ON_ERR(1)) d1 (.i_clk(clk), .i_rstn(rstn), .bus(if1));
    alu_resp_checker #(.MAX_SAMPLES(8)) d2 (.i_clk(clk), .i_rstn(rstn), .bus(if2));
    alu_resp_checker #(.CNT_W(2))       d3 (.i_clk(clk), .i_rstn(rstn), .bus(if3));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] ff, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] oo, input logic cc);
        valid = v; f = ff; a = aa; b = bb; op = oo; c = cc;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", if0.o_busy, 0);
        chk("rst_pass", if0.o_pass_cnt, 0);
        rstn = 1'b1;
        tick();

        // Samples in IDLE are ignored
        drv(1, 3'd2, 32'h1, 32'h1, 32'h2, 0);
        tick(); drv(0, 0, 0, 0, 0, 0); tick(); tick();
        chk("idle_ignored_pass", if0.o_pass_cnt, 0);
        chk("idle_busy", if0.o_busy, 0);

        // Three mismatches, then async reset mid-RUN
        start = 1; tick(); start = 0;
        chk("start_busy", if0.o_busy, 1);
        drv(1, 3'd0, 32'hF0, 32'hFF, 32'h0, 0);
        tick(); tick(); tick();
        drv(0, 0, 0, 0, 0, 0); tick();
        chk("pre_rst_fail3", if0.o_fail_cnt, 3);
        chk("pre_rst_errexp", if0.o_err_exp, 32'hF0);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_fail", if0.o_fail_cnt, 0);
        chk("async_rst_err", if0.o_err, 0);
        chk("async_rst_errexp", if0.o_err_exp, 0);
        chk("async_rst_busy", if0.o_busy, 0);
        chk("async_rst_done", if0.o_done, 0);
        #1 rstn = 1'b1;
        tick();

        // Carry-out on wrap-around add; one-cycle latency
        start = 1; tick(); start = 0;
        drv(1, 3'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        tick(); drv(0, 0, 0, 0, 0, 0);
        chk("add_latency_pass0", if0.o_pass_cnt, 0);
        tick();
        chk("add_pass1", if0.o_pass_cnt, 1);
        chk("add_err0", if0.o_err, 0);

        // Subtract passes; signed SLT mismatch captured
        drv(1, 3'd6, 32'h5, 32'h7, 32'hFFFF_FFFE, 0); tick();
        drv(1, 3'd7, 32'h8000_0000, 32'h1, 32'h0, 1); tick();
        drv(0, 0, 0, 0, 0, 0); tick();
        chk("sub_pass2", if0.o_pass_cnt, 2);
        chk("slt_fail1", if0.o_fail_cnt, 1);
        chk("slt_err", if0.o_err, 1);
        chk("slt_err_f", if0.o_err_f, 3'b111);
        chk("slt_err_exp", if0.o_err_exp, 1);
        chk("slt_err_got", if0.o_err_got, 0);
        // Later mismatch counts but leaves capture alone
        drv(1, 3'd0, 32'hF0, 32'hFF, 32'h0, 0); tick();
        drv(0, 0, 0, 0, 0, 0); tick();
        chk("second_fail2", if0.o_fail_cnt, 2);
        chk("capture_kept_f", if0.o_err_f, 3'b111);
        chk("capture_kept_exp", if0.o_err_exp, 1);

        // Stop on first error (d1)
        start = 1; tick(); start = 0;
        drv(1, 3'd1, 32'h3, 32'h5, 32'h7, 0); tick();
        drv(1, 3'd0, 32'h3, 32'h5, 32'h2, 0); tick();
        chk("soe_done", if1.o_done, 1);
        chk("soe_busy", if1.o_busy, 0);
        drv(1, 3'd1, 32'h3, 32'h5, 32'h7, 0); tick(); tick();
        drv(0, 0, 0, 0, 0, 0); tick();
        chk("soe_pass1", if1.o_pass_cnt, 1);
        chk("soe_fail1", if1.o_fail_cnt, 1);
        chk("soe_err_got", if1.o_err_got, 2);

        // Sample limit (d2) and full reference sweep (d0)
        start = 1; tick(); start = 0;
        for (int fi = 0; fi < 8; fi++) begin
            for (int k = 0; k < 8; k++) begin
                drv(1, fi[2:0], 32'hC, 32'hA, eop[fi], ec[fi]);
                tick();
                if (fi == 0 && k == 6) chk("max_not_done7", if2.o_done, 0);
                if (fi == 0 && k == 7) chk("max_done8", if2.o_done, 1);
            end
        end
        // Stop together with a valid sample: sample still counted
        drv(1, 3'd7, 32'hC, 32'hA, 32'h0, 1);
        stop = 1; tick(); stop = 0;
        drv(0, 0, 0, 0, 0, 0);
        chk("stop_done", if0.o_done, 1);
        chk("sweep_pass64", if0.o_pass_cnt, 64);
        tick();
        chk("stop_valid_pass65", if0.o_pass_cnt, 65);
        chk("sweep_fail0", if0.o_fail_cnt, 0);
        chk("max_pass8", if2.o_pass_cnt, 8);
        chk("max_fail0", if2.o_fail_cnt, 0);
        // Restart clears
        start = 1; tick(); start = 0; tick();
        chk("restart_busy", if2.o_busy, 1);
        chk("restart_pass0", if2.o_pass_cnt, 0);

        // Start discards an in-flight sample
        drv(1, 3'd0, 32'hC, 32'hA, 32'h8, 0); tick();
        drv(0, 0, 0, 0, 0, 0);
        start = 1; tick(); start = 0; tick();
        chk("inflight_discard", if0.o_pass_cnt, 0);

        // Saturation with CNT_W=2 (d3)
        drv(1, 3'd0, 32'hC, 32'hA, 32'h8, 0);
        for (int k = 0; k < 5; k++) tick();
        drv(0, 0, 0, 0, 0, 0); tick();
        chk("sat_pass3", if3.o_pass_cnt, 3);
        chk("nosat_pass5", if0.o_pass_cnt, 5);
        // Start with stop: start wins
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        chk("startstop_busy", if3.o_busy, 1);
        chk("startstop_pass0", if3.o_pass_cnt, 0);
        chk("startstop_done0", if3.o_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
